// File: rtl/tpg_seq_ctrl.sv
// Raster timing and frame-aligned pattern mode sequencer for the TPG.
// Define TPG_SEQ_AUTO_EN to build the dwell counter and automatic mode cycling.
module tpg_seq_ctrl #(
    parameter int unsigned H_ACTIVE     = 1920,
    parameter int unsigned H_FP         = 88,
    parameter int unsigned H_SYNC       = 44,
    parameter int unsigned H_BP         = 148,
    parameter int unsigned V_ACTIVE     = 1080,
    parameter int unsigned V_FP         = 4,
    parameter int unsigned V_SYNC       = 5,
    parameter int unsigned V_BP         = 36,
    parameter logic        SYNC_POL     = 1'b1,
    parameter int unsigned DWELL_FRAMES = 64,
    parameter int unsigned NUM_MODES    = 16
) (
    input  logic        seq_clk_i,
    input  logic        seq_rst_i,
    input  logic        en_i,
    input  logic        auto_i,
    input  logic        mode_req_i,
    input  logic [3:0]  mode_sel_i,
    output logic        mode_ack_o,
    output logic        vs_o,
    output logic        hs_o,
    output logic        de_o,
    output logic [3:0]  mode_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HLast    = 12'(H_TOTAL - 1);
    localparam logic [11:0] VLast    = 12'(V_TOTAL - 1);
    localparam logic [12:0] HActive  = 13'(H_ACTIVE);
    localparam logic [12:0] VActive  = 13'(V_ACTIVE);
    localparam logic [12:0] HsStart  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HsEnd    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VsStart  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VsEnd    = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  ModeMax  = 4'(NUM_MODES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e      st_q, st_d;
    logic [11:0] h_q, h_d, v_q, v_d;
    logic        boundary;
    logic [3:0]  mode_q, mode_d;
    logic        ack_d, de_d, hs_d, vs_d;
    logic        ack_q, de_q, hs_q, vs_q, fs_q;
    logic [15:0] fcnt_q;

`ifdef TPG_SEQ_AUTO_EN
    localparam int unsigned DwellW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_FRAMES - 1);
    logic [DwellW-1:0] dwell_q, dwell_d;
`else
    logic unused_auto;
    assign unused_auto = auto_i;
`endif

    // Next raster position; boundary marks the cycle about to show h=v=0 in RUN.
    always_comb begin
        st_d     = st_q;
        h_d      = h_q;
        v_d      = v_q;
        boundary = 1'b0;
        case (st_q)
            StIdle: begin
                h_d = '0;
                v_d = '0;
                if (en_i) begin
                    st_d     = StRun;
                    boundary = 1'b1;
                end
            end
            StRun, StDrain: begin
                if (h_q == HLast && v_q == VLast) begin
                    h_d = '0;
                    v_d = '0;
                    if (en_i) begin
                        st_d     = StRun;
                        boundary = 1'b1;
                    end else begin
                        st_d = StIdle;
                    end
                end else begin
                    if (h_q == HLast) begin
                        h_d = '0;
                        v_d = v_q + 12'd1;
                    end else begin
                        h_d = h_q + 12'd1;
                    end
                    st_d = en_i ? StRun : StDrain;
                end
            end
            default: begin
                st_d = StIdle;
                h_d  = '0;
                v_d  = '0;
            end
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        ack_d  = 1'b0;
`ifdef TPG_SEQ_AUTO_EN
        dwell_d = dwell_q;
`endif
        if (boundary) begin
            if (mode_req_i) begin
                mode_d = (mode_sel_i > ModeMax) ? ModeMax : mode_sel_i;
                ack_d  = 1'b1;
`ifdef TPG_SEQ_AUTO_EN
                dwell_d = '0;
`endif
            end
`ifdef TPG_SEQ_AUTO_EN
            else if (auto_i) begin
                if (dwell_q == DwellLast) begin
                    mode_d  = (mode_q == ModeMax) ? 4'd0 : mode_q + 4'd1;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
`endif
        end
    end

    // Outputs are decoded from the next position so they register in step with it.
    always_comb begin
        logic        active;
        logic [12:0] hx, vx;
        active = (st_d != StIdle);
        hx     = {1'b0, h_d};
        vx     = {1'b0, v_d};
        de_d   = active && (hx < HActive) && (vx < VActive);
        hs_d   = (active && hx >= HsStart && hx < HsEnd) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (active && vx >= VsStart && vx < VsEnd) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge seq_clk_i) begin
        if (seq_rst_i) begin
            st_q   <= StIdle;
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= '0;
            ack_q  <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            fs_q   <= 1'b0;
            fcnt_q <= '0;
`ifdef TPG_SEQ_AUTO_EN
            dwell_q <= '0;
`endif
        end else begin
            st_q   <= st_d;
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            ack_q  <= ack_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= boundary;
            if (boundary) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
`ifdef TPG_SEQ_AUTO_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    assign mode_ack_o    = ack_q;
    assign vs_o          = vs_q;
    assign hs_o          = hs_q;
    assign de_o          = de_q;
    assign mode_o        = mode_q;
    assign frame_start_o = fs_q;
    assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_tpg_seq_ctrl.sv
// Directed bench for tpg_seq_ctrl on an 8x6 raster (48 cycles per frame).
`timescale 1ns/1ps
module tb_tpg_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        auto_m = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        ack, vs, hs, de, fs;
    logic [3:0]  mode;
    logic [15:0] fcnt;

    int          checks = 0;
    int          errors = 0;
    int          cur_off = 0;
    int unsigned exp_fc = 0;

    typedef struct {
        int   off;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } rast_t;

    rast_t rtab [15];

`ifdef TPG_SEQ_AUTO_EN
    typedef struct {
        logic       req;
        logic [3:0] sel;
        logic [3:0] mode;
        logic       ack;
    } mode_vec_t;

    mode_vec_t mtab [11];
`endif

    always #5 clk = ~clk;

    tpg_seq_ctrl #(
        .H_ACTIVE    (4),
        .H_FP        (1),
        .H_SYNC      (2),
        .H_BP        (1),
        .V_ACTIVE    (3),
        .V_FP        (1),
        .V_SYNC      (1),
        .V_BP        (1),
        .SYNC_POL    (1'b1),
        .DWELL_FRAMES(2),
        .NUM_MODES   (4)
    ) dut (
        .seq_clk_i    (clk),
        .seq_rst_i    (rst),
        .en_i         (en),
        .auto_i       (auto_m),
        .mode_req_i   (req),
        .mode_sel_i   (sel),
        .mode_ack_o   (ack),
        .vs_o         (vs),
        .hs_o         (hs),
        .de_o         (de),
        .mode_o       (mode),
        .frame_start_o(fs),
        .frame_cnt_o  (fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic go_off(input int target);
        while (cur_off < target) begin
            tick();
            cur_off++;
        end
    endtask

    task automatic wait_fs(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs && n < 200);
        cur_off = 0;
        exp_fc  = (exp_fc + 1) & 32'hffff;
        chk({name, " frame_start"}, 32'(fs), 32'd1);
        chk({name, " frame_cnt"}, 32'(fcnt), exp_fc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Offset is v*8+h within the first frame.
        rtab[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1};
        rtab[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0};
        rtab[2]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0};
        rtab[3]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0};
        rtab[4]  = '{5,  1'b0, 1'b1, 1'b0, 1'b0};
        rtab[5]  = '{6,  1'b0, 1'b1, 1'b0, 1'b0};
        rtab[6]  = '{7,  1'b0, 1'b0, 1'b0, 1'b0};
        rtab[7]  = '{8,  1'b1, 1'b0, 1'b0, 1'b0};
        rtab[8]  = '{21, 1'b0, 1'b1, 1'b0, 1'b0};
        rtab[9]  = '{24, 1'b0, 1'b0, 1'b0, 1'b0};
        rtab[10] = '{32, 1'b0, 1'b0, 1'b1, 1'b0};
        rtab[11] = '{37, 1'b0, 1'b1, 1'b1, 1'b0};
        rtab[12] = '{39, 1'b0, 1'b0, 1'b1, 1'b0};
        rtab[13] = '{40, 1'b0, 1'b0, 1'b0, 1'b0};
        rtab[14] = '{47, 1'b0, 1'b0, 1'b0, 1'b0};

`ifdef TPG_SEQ_AUTO_EN
        // Starts at mode 3, dwell 0; entry 4 restarts dwell, entry 8 overrides an advance.
        mtab[0]  = '{1'b0, 4'd0, 4'd3, 1'b0};
        mtab[1]  = '{1'b0, 4'd0, 4'd0, 1'b0};
        mtab[2]  = '{1'b0, 4'd0, 4'd0, 1'b0};
        mtab[3]  = '{1'b0, 4'd0, 4'd1, 1'b0};
        mtab[4]  = '{1'b1, 4'd2, 4'd2, 1'b1};
        mtab[5]  = '{1'b0, 4'd0, 4'd2, 1'b0};
        mtab[6]  = '{1'b0, 4'd0, 4'd3, 1'b0};
        mtab[7]  = '{1'b0, 4'd0, 4'd3, 1'b0};
        mtab[8]  = '{1'b1, 4'd3, 4'd3, 1'b1};
        mtab[9]  = '{1'b0, 4'd0, 4'd3, 1'b0};
        mtab[10] = '{1'b0, 4'd0, 4'd0, 1'b0};
`endif

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset outputs", 32'({ack, vs, hs, de, fs, mode, fcnt}), 32'd0);
        repeat (4) tick();
        chk("idle de", 32'(de), 32'd0);
        chk("idle frame_cnt", 32'(fcnt), 32'd0);

        // Start latency and first-frame raster
        en = 1'b1;
        tick();
        cur_off = 0;
        exp_fc  = 1;
        chk("start frame_start", 32'(fs), 32'd1);
        chk("start de", 32'(de), 32'd1);
        chk("start mode", 32'(mode), 32'd0);
        chk("start frame_cnt", 32'(fcnt), 32'd1);
        for (int i = 0; i < 15; i++) begin
            go_off(rtab[i].off);
            chk($sformatf("raster@%0d {de,hs,vs,fs}", rtab[i].off), 32'({de, hs, vs, fs}),
                32'({rtab[i].de, rtab[i].hs, rtab[i].vs, rtab[i].fs}));
        end
        tick();
        cur_off = 0;
        exp_fc  = 2;
        chk("second frame_start at 48", 32'(fs), 32'd1);
        chk("second frame_cnt", 32'(fcnt), 32'd2);
        go_off(1);
        chk("frame_start pulse width", 32'(fs), 32'd0);

        // Manual request mid-frame
        req = 1'b1;
        sel = 4'd2;
        go_off(2);
        chk("req no mid-frame change", 32'({ack, mode}), 32'({1'b0, 4'd0}));
        wait_fs("req2");
        chk("req2 ack", 32'(ack), 32'd1);
        chk("req2 mode", 32'(mode), 32'd2);
        req = 1'b0;
        go_off(1);
        chk("req2 ack pulse", 32'({ack, mode}), 32'({1'b0, 4'd2}));

        // Clamp
        req = 1'b1;
        sel = 4'd9;
        wait_fs("clamp");
        chk("clamp ack+mode", 32'({ack, mode}), 32'({1'b1, 4'd3}));
        req = 1'b0;

        // Request withdrawn before boundary
        req = 1'b1;
        sel = 4'd1;
        go_off(cur_off + 3);
        req = 1'b0;
        wait_fs("dropped");
        chk("dropped req ignored", 32'({ack, mode}), 32'({1'b0, 4'd3}));

`ifdef TPG_SEQ_AUTO_EN
        auto_m = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (mtab[i].req) begin
                req = 1'b1;
                sel = mtab[i].sel;
            end
            wait_fs($sformatf("auto[%0d]", i));
            chk($sformatf("auto[%0d] {ack,mode}", i), 32'({ack, mode}),
                32'({mtab[i].ack, mtab[i].mode}));
            req = 1'b0;
        end
        auto_m = 1'b0;
`else
        auto_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_fs($sformatf("noauto[%0d]", i));
            chk($sformatf("noauto[%0d] {ack,mode}", i), 32'({ack, mode}), 32'({1'b0, 4'd3}));
        end
        auto_m = 1'b0;
`endif

        // Stop at h=2,v=1: frame drains then idles
        go_off(10);
        en = 1'b0;
        go_off(16);
        chk("drain de at v2", 32'(de), 32'd1);
        go_off(47);
        tick();
        chk("stopped outputs", 32'({de, hs, vs, fs}), 32'd0);
        chk("stopped frame_cnt", 32'(fcnt), exp_fc);
        repeat (5) tick();
        chk("idle after drain", 32'({de, fs}), 32'd0);
        en = 1'b1;
        tick();
        cur_off = 0;
        exp_fc  = exp_fc + 1;
        chk("restart frame_start", 32'({fs, de}), 32'b11);
        chk("restart frame_cnt", 32'(fcnt), exp_fc);

        // Re-enable during drain: next frame is contiguous
        go_off(10);
        en = 1'b0;
        go_off(15);
        en = 1'b1;
        go_off(47);
        chk("no early frame_start", 32'(fs), 32'd0);
        tick();
        cur_off = 0;
        exp_fc  = exp_fc + 1;
        chk("contiguous frame_start", 32'(fs), 32'd1);
        chk("contiguous frame_cnt", 32'(fcnt), exp_fc);

        // Reset mid-frame at v=2
        req = 1'b1;
        sel = 4'd2;
        wait_fs("prereset");
        chk("prereset mode", 32'({ack, mode}), 32'({1'b1, 4'd2}));
        req = 1'b0;
        go_off(16);
        rst = 1'b1;
        tick();
        chk("midframe reset outputs", 32'({ack, vs, hs, de, fs, mode, fcnt}), 32'd0);
        rst = 1'b0;
        exp_fc = 0;
        tick();
        chk("post-reset start", 32'({fs, mode}), 32'({1'b1, 4'd0}));
        chk("post-reset frame_cnt", 32'(fcnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
